// File: rtl/jump_reg_hazard_ctrl.sv
// jump_reg_hazard_ctrl: jr/jalr target forwarding select and stall control from an EX/MEM/WB destination shadow
module jump_reg_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic             iIDJumpReg,
  input  logic [4:0]       iIDRs,
  input  logic             iIDRegWrite,
  input  logic [4:0]       iIDRegDst,
  input  logic             iIDMemRead,
  input  logic             iExtStall,
  input  logic             iFlush,
  output logic [1:0]       oEXForwardJ,
  output logic             oStall,
  output logic             oJumpGo,
  output logic [CNT_W-1:0] oStallCnt
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state, stateNext;
  logic exValid, memValid, wbValid, exLoad, memLoad;
  logic [4:0] exDst, memDst, wbDst;
  logic lookup, exHit, memHit, wbHit, hazStall;
  assign lookup = iIDJumpReg & (iIDRs != 5'd0);
  assign exHit = lookup & exValid & (exDst == iIDRs);
  assign memHit = lookup & memValid & (memDst == iIDRs);
  assign wbHit = lookup & wbValid & (wbDst == iIDRs);
  // youngest producer wins; a load in EX or an ALU result in MEM has no path yet
  assign hazStall = exHit ? exLoad : memHit & ~memLoad;
  assign oEXForwardJ = exHit ? (exLoad ? 2'b00 : 2'b01) :
                       memHit ? (memLoad ? 2'b10 : 2'b00) :
                       wbHit ? 2'b11 : 2'b00;
  assign oStall = hazStall & ~iFlush;
  assign oJumpGo = iIDJumpReg & ~oStall & ~iExtStall & ~iFlush;
  // shadow of in-flight destinations; a bubble enters EX whenever ID does not advance
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      {exValid, exDst, exLoad} <= '0;
      {memValid, memDst, memLoad} <= '0;
      {wbValid, wbDst} <= '0;
    end else begin
      {wbValid, wbDst} <= {memValid, memDst};
      {memValid, memDst, memLoad} <= {exValid, exDst, exLoad};
      {exValid, exDst, exLoad} <= (oStall | iExtStall | iFlush) ? 7'd0 :
                                  {iIDRegWrite & (iIDRegDst != 5'd0), iIDRegDst, iIDMemRead};
    end
  end
  // stall-tracking state register
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) state <= S_IDLE;
    else state <= stateNext;
  end
  // enter WAIT on a stall, leave once the jr resolves, is squashed or leaves ID
  always_comb begin
    stateNext = oStall ? S_WAIT : (oJumpGo | iFlush | ~iIDJumpReg) ? S_IDLE : state;
  end
  // saturating stall-cycle counter
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) oStallCnt <= '0;
    else oStallCnt <= (oStall && oStallCnt != '1) ? oStallCnt + 1'b1 : oStallCnt;
  end
  // every jr hazard clears after a single bubble, so a waiting jr never stalls again
  assert property (@(posedge iClk) disable iff (iReset) !(state == S_WAIT && oStall));
endmodule
